// File: rtl/press_decode.sv
`default_nettype none
// ============================================================================
// Module      : press_decode
// Description : Classifies each debounced press into a short, long or double
//               gesture. It advances only on tick-enable cycles, emits
//               one-clock event pulses, and reports held/busy levels.
// Revision    : 1.0 - initial release
// ============================================================================
module press_decode #(
  parameter int CW     = 8,
  parameter int LONG_T = 50,
  parameter int GAP_T  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // Terminal counts; cnt starts at 0 on state entry, so the last tick is T-1
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_T - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_T - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          short_nx;
  logic          long_nx;
  logic          dbl_nx;

  // Next-state, counter and pulse decode; nothing moves on non-tick cycles
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    dbl_nx   = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (i) state_nx = PRESS;
        end
        PRESS: begin
          if (!i) begin
            state_nx = GAP;
          end else if (cnt == LONG_LAST) begin
            state_nx = LONG;
            long_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        GAP: begin
          if (i) begin
            state_nx = PRESS2;
          end else if (cnt == GAP_LAST) begin
            state_nx = IDLE;
            short_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        PRESS2: begin
          if (!i) begin
            state_nx = IDLE;
            dbl_nx   = 1'b1;
          end else if (cnt == LONG_LAST) begin
            // First press was short, second one has now become long
            state_nx = LONG;
            short_nx = 1'b1;
            long_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        LONG: begin
          if (!i) state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
      // Every state change restarts the tick count
      if (state_nx != state) cnt_nx = '0;
    end
  end

  // State, counter and registered outputs; pulses self-clear off-tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      dbl_p   <= 1'b0;
      held    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      short_p <= short_nx;
      long_p  <= long_nx;
      dbl_p   <= dbl_nx;
      held    <= (state_nx == LONG);
      busy    <= (state_nx != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_press_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_decode
// Description : Scoreboard bench for press_decode with a run-length gesture
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_decode;

  localparam int CW     = 8;
  localparam int LONG_T = 4;
  localparam int GAP_T  = 3;

  logic clk;
  logic rst_n;
  logic en;
  logic i;
  logic short_p;
  logic long_p;
  logic dbl_p;
  logic held;
  logic busy;

  press_decode #(.CW(CW), .LONG_T(LONG_T), .GAP_T(GAP_T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i       (i),
    .short_p (short_p),
    .long_p  (long_p),
    .dbl_p   (dbl_p),
    .held    (held),
    .busy    (busy)
  );

  // Expected event: the edge number that decides it and {dbl,long,short}
  typedef struct {
    int         cyc;
    logic [2:0] code;
  } ev_t;

  ev_t  sb[$];
  int   checks  = 0;
  int   fails   = 0;
  int   edge_no = 0;
  bit   done    = 0;
  bit   exp_held = 0;
  bit   exp_busy = 0;

  // Reference model: the gesture in flight is a list of tick run lengths,
  // alternating pressed/released and starting with a pressed run.
  int   runs[$];
  bit   long_mode = 0;

  function automatic logic [2:0] model_tick(input bit s);
    logic [2:0] ev;
    int n;
    ev = 3'b000;
    if (long_mode) begin
      if (!s) long_mode = 0;
    end else if (runs.size() == 0) begin
      if (s) runs.push_back(1);
    end else begin
      n = runs.size();
      if (s == bit'(n % 2)) runs[n-1] = runs[n-1] + 1;
      else runs.push_back(1);
      n = runs.size();
      if (n == 1 && runs[0] == LONG_T + 1) begin
        ev = 3'b010; long_mode = 1; runs.delete();
      end else if (n == 2 && runs[1] == GAP_T + 1) begin
        ev = 3'b001; runs.delete();
      end else if (n == 3 && runs[2] == LONG_T + 1) begin
        ev = 3'b011; long_mode = 1; runs.delete();
      end else if (n == 4) begin
        ev = 3'b100; runs.delete();
      end
    end
    exp_held = long_mode;
    exp_busy = long_mode || (runs.size() != 0);
    return ev;
  endfunction

  function automatic void model_reset();
    runs.delete();
    long_mode = 0;
    exp_held  = 0;
    exp_busy  = 0;
    sb.delete();
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; the model advances on the same edge
  task automatic step(input bit e, input bit s);
    logic [2:0] ev;
    ev_t x;
    en = e;
    i  = s;
    @(posedge clk);
    edge_no++;
    if (rst_n && e) begin
      ev = model_tick(s);
      if (ev != 3'b000) begin
        x.cyc  = edge_no;
        x.code = ev;
        sb.push_back(x);
      end
    end
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({short_p, long_p, dbl_p, held, busy} != 5'b0) begin
      fails++;
      $display("FAIL %s: outputs {short,long,dbl,held,busy}=%b, required 00000",
               name, {short_p, long_p, dbl_p, held, busy});
    end
  endtask

  // Asynchronous reset asserted between edges, held for a few cycles
  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    step(1, 1);
    step(1, 0);
    rst_n = 1'b1;
  endtask

  task automatic press_seq(input bit e, input int hi, input int lo);
    for (int k = 0; k < hi; k++) step(e, 1);
    for (int k = 0; k < lo; k++) step(e, 0);
  endtask

  // Monitor: pops the scoreboard when the DUT pulses or an event falls due
  always @(negedge clk) begin
    logic [2:0] got;
    ev_t e;
    if (!done) begin
      got = {dbl_p, long_p, short_p};
      if (sb.size() > 0 && sb[0].cyc <= edge_no) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != edge_no || e.code != got) begin
          fails++;
          $display("FAIL event @edge %0d: got {dbl,long,short}=%b, required %b (due edge %0d)",
                   edge_no, got, e.code, e.cyc);
        end
      end else if (got != 3'b000) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse @edge %0d: got {dbl,long,short}=%b, required 000",
                 edge_no, got);
      end
      checks++;
      if (held !== exp_held || busy !== exp_busy) begin
        fails++;
        $display("FAIL levels @edge %0d: held=%b busy=%b, required held=%b busy=%b",
                 edge_no, held, busy, exp_held, exp_busy);
      end
    end
  end

  initial begin
    bit s;
    bit e;
    rst_n = 1'b0;
    en    = 1'b0;
    i     = 1'b0;
    step(1, 1);
    step(1, 1);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    press_seq(1, 0, 3);

    // Short press
    press_seq(1, 2, 8);
    // Long press
    press_seq(1, 10, 4);
    // Double press
    step(1, 1); step(1, 1); step(1, 0); step(1, 0);
    step(1, 1); step(1, 1); step(1, 0);
    press_seq(1, 0, 4);
    // Short then long
    step(1, 1); step(1, 0); step(1, 1);
    press_seq(1, 8, 4);
    // Slow tick, with i toggling between ticks
    for (int t = 0; t < 2; t++) begin
      step(1, 1); step(0, 0); step(0, 1); step(0, 0);
    end
    for (int t = 0; t < 6; t++) begin
      step(1, 0); step(0, 1); step(0, 0); step(0, 1);
    end
    // Reset while in the second press, then a normal short press
    step(1, 1); step(1, 1); step(1, 0); step(1, 1);
    mid_reset();
    press_seq(1, 0, 3);
    press_seq(1, 2, 8);

    // Random traffic with a mix of tick rates and press lengths
    s = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      if (k < 1000)      e = 1'b1;
      else if (k < 2000) e = ($urandom_range(0, 3) == 0);
      else               e = ($urandom_range(0, 1) == 0);
      step(e, s);
      if (k == 1500 || k == 2500) mid_reset();
    end
    press_seq(1, 0, 12);

    @(negedge clk);
    done = 1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d events outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/press_decode.md
# press_decode

Gesture decoder placed directly downstream of the `filt4` glitch filter. It consumes the filter's clean level `y` and classifies each press into a short press, a long press or a double press, emitting one-clock event pulses. It advances only on the same `en` ticks that pace the filter, so all hold and gap times are expressed in ticks.

## Interface
- `CW`, 8: width of the tick counter.
- `LONG_T`, 50: ticks a press must persist beyond its first sample to count as long; legal range 1..2^CW-1.
- `GAP_T`, 20: ticks of release after a first press within which a second press makes a double; legal range 1..2^CW-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  tick enable, shared with `filt4`; state and counter update only when high.
- `i`  in  1  filtered level, driven by `filt4.y`; 1 = pressed.
- `short_p`  out  1  one-clk pulse: single short press completed.
- `long_p`  out  1  one-clk pulse: press reached long threshold.
- `dbl_p`  out  1  one-clk pulse: double press completed.
- `held`  out  1  level: a long press is in progress.
- `busy`  out  1  level: FSM not in IDLE.

## Operation
- States:
  - IDLE = 0
  - PRESS = 1
  - GAP = 2
  - PRESS2 = 3
  - LONG = 4
- Encoding is 3 bits; any illegal state returns to IDLE on the next tick.
- `cnt` is CW bits wide. It clears to 0 on every state change and otherwise increments by 1 per tick. Comparisons are unsigned equality against `LONG_T-1` or `GAP_T-1`, so `cnt` never wraps.
- Transitions are evaluated only on tick cycles (`en`=1):
  - IDLE: `i`=1 -> PRESS.
  - PRESS:
    - `i`=0 -> GAP.
    - else `cnt`==LONG_T-1 -> LONG, pulse `long_p`.
    - else `cnt`++.
  - GAP:
    - `i`=1 -> PRESS2.
    - else `cnt`==GAP_T-1 -> IDLE, pulse `short_p`.
    - else `cnt`++.
  - PRESS2:
    - `i`=0 -> IDLE, pulse `dbl_p`.
    - else `cnt`==LONG_T-1 -> LONG, pulse `short_p` and `long_p` in the same cycle, so the first press is reported as short and the second as long.
    - else `cnt`++.
  - LONG: `i`=0 -> IDLE, with no pulse.
- Level outputs:
  - `held` = (state==LONG).
  - `busy` = (state!=IDLE).
- Outputs and counter are registered.

## Timing
- Reset (async assert, synchronous to `clk` on deassert):
  - state = IDLE, `cnt` = 0.
  - `short_p`, `long_p`, `dbl_p`, `held`, `busy` = 0.
- Reset mid-gesture discards the gesture and emits no pulse.
- Pulse timing:
  - Each event pulse is high exactly one `clk` cycle: the cycle after the tick edge that decides it.
  - Pulses deassert on the next edge regardless of `en`.
  - `held` and `busy` change on the same edge as the state.
- `en`=0:
  - State and `cnt` hold.
  - `i` is ignored.
  - Pulses still fall after one cycle.
- Latency with `en` held at 1, press rising at tick 0:
  - Long press: `long_p` is visible on clk LONG_T+1 after the edge sampling `i`=1 in IDLE.
  - Short press: `short_p` follows the release sample by GAP_T ticks plus one clock.
- A press shorter than one tick is invisible; this is by design, since `filt4` guarantees minimum widths.
- At most one gesture is in flight; no queuing.

## Test plan
All scenarios use LONG_T=4, GAP_T=3, CW=8.
- Short press, `en`=1 always: `i` high 2 cycles then low -> `short_p` pulses once, exactly 4 clk after the first low sample; `busy` high from the first high sample until that pulse; `long_p`, `dbl_p` stay 0.
- Long press, `en`=1: `i` high 10 cycles -> `long_p` pulses once on clk 5 after the first high sample; `held`=1 from then until the clk after `i` falls; no `short_p`.
- Double press, `en`=1: `i` = 1,1,0,0,1,1,0 -> `dbl_p` pulses once after the final 0; `short_p` = 0; FSM back to IDLE (`busy`=0).
- Short-then-long, `en`=1: `i` = 1,0,1 then 1 held 8 cycles -> `short_p` and `long_p` pulse in the same cycle; `held`=1 afterwards.
- Slow tick: `en` high every 4th clk, short press of 2 ticks -> `short_p` fires 3 ticks after release; `i` toggles between ticks have no effect; pulse width is 1 clk.
- Reset mid-op: assert `rst_n`=0 while in PRESS2 -> all outputs 0 immediately; after release, no pulse; the next short press decodes normally.
